// File: rtl/divide_6_seq_pkg.sv
// Shared definitions for the bit-serial divide-by-6 block.
// Holds the state encoding and the remainder width used by the step logic.
package divide_6_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIVISOR = 6;
  localparam int REM_W   = 3;

endpackage

// File: rtl/divide_6_seq_mod6_step.sv
// One restoring-division step by 6: folds one dividend bit into a 0..5 remainder.
// Reusable by the combinational divisibility checkers as a single stage.
module mod6_step
  import divide_6_seq_pkg::*;
(
  input  logic [REM_W-1:0] r_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] r_out,
  output logic             q_bit
);

  localparam logic [REM_W:0]   DIV_WIDE = DIVISOR[REM_W:0];
  localparam logic [REM_W-1:0] DIV_NARR = DIVISOR[REM_W-1:0];

  logic [REM_W:0] t;

  // For t in 6..11 the low three bits minus 6 (mod 8) give exactly t-6.
  always_comb begin
    t     = {r_in, bit_in};
    q_bit = (t >= DIV_WIDE);
    r_out = q_bit ? (t[REM_W-1:0] - DIV_NARR) : t[REM_W-1:0];
  end

endmodule

// File: rtl/divide_6_seq.sv
// Bit-serial unsigned divider by 6: accepts a dividend, shifts it MSB-first
// through a mod-6 step for WIDTH cycles, then presents quotient/remainder.
//
// state | meaning
// IDLE  | waiting for a dividend, in_ready high
// SHIFT | one dividend bit consumed per clock
// DONE  | result presented until out_ready
module divide_6_seq
  import divide_6_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [2:0]       remainder,
  output logic             divisible
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W-1:0] rem_q;
  logic             div_q;

  logic [REM_W-1:0] r_next;
  logic             q_bit;
  logic             accept;
  logic             last_step;

  mod6_step u_step (
    .r_in  (rem_q),
    .bit_in(shift_q[WIDTH-1]),
    .r_out (r_next),
    .q_bit (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        last_step = (cnt_q == '0);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers keep the last answer through IDLE until the next dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= 1'b0;
    end else if (accept) begin
      shift_q <= dividend;
      rem_q   <= '0;
      cnt_q   <= CNT_LOAD;
    end else if (state_q == SHIFT) begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      quot_q  <= {quot_q[WIDTH-2:0], q_bit};
      rem_q   <= r_next;
      if (last_step) div_q <= (r_next == '0);
      else           cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign divisible = div_q;

endmodule

// File: tb/tb_divide_6_seq.sv
// Self-checking bench for divide_6_seq (WIDTH=8) against plain x/6, x%6 arithmetic.
module tb_divide_6_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [2:0]   remainder;
  logic         divisible;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  divide_6_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .divisible(divisible)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present x until accepted; returns the cycle stamp of the accepting edge.
  task automatic accept_one(input logic [W-1:0] x, output bit ok, output int stamp);
    int n = 0;
    ok = 1'b0;
    stamp = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (in_ready) begin
      in_valid = 1'b1;
      dividend = x;
      tick();
      stamp = cyc;
      in_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, divisible} !== {1'b1, 1'b0, 8'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d d=%b, required rdy=1 vld=0 q=0 r=0 d=0",
               in_ready, out_valid, quotient, remainder, divisible);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    bit ok; int lat; int st;
    accept_one(8'd0, ok, st);
    wait_valid(lat, ok);
    vectors++;
    if (!ok || lat != W) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d edges (valid=%b), required %0d", lat, ok, W);
    end
    vectors++;
    if ({quotient, remainder, divisible} !== {8'd0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_result: q=%0d r=%0d d=%b, required q=0 r=0 d=1", quotient, remainder, divisible);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_return: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; int st0; int st1; int busy_bad;
    logic [W-1:0] xs [2] = '{8'd6, 8'd255};
    int stamps [2];
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      accept_one(xs[k], ok, stamps[k]);
      busy_bad = 0;
      lat = 0;
      while (!out_valid && lat < 200) begin
        if (in_ready) busy_bad++;
        tick();
        lat++;
      end
      if (in_ready) busy_bad++;
      vectors++;
      if (busy_bad != 0 || !out_valid) begin
        miscompares++;
        $display("FAIL b2b_in_ready: in_ready high %0d times while busy (valid=%b), required 0", busy_bad, out_valid);
      end
      vectors++;
      if ({quotient, remainder, divisible} !== {W'(xs[k] / 6), 3'(xs[k] % 6), 1'(xs[k] % 6 == 0)}) begin
        miscompares++;
        $display("FAIL b2b_result x=%0d: q=%0d r=%0d d=%b, required q=%0d r=%0d d=%b", xs[k],
                 quotient, remainder, divisible, xs[k] / 6, xs[k] % 6, (xs[k] % 6) == 0);
      end
      tick();
    end
    st0 = stamps[0];
    st1 = stamps[1];
    vectors++;
    if (st1 - st0 != W + 2) begin
      miscompares++;
      $display("FAIL b2b_throughput: %0d cycles between acceptances, required %0d", st1 - st0, W + 2);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int st; int bad = 0;
    out_ready = 1'b0;
    accept_one(8'd47, ok, st);
    wait_valid(lat, ok);
    for (int i = 0; i < 20; i++) begin
      if ({out_valid, in_ready, quotient, remainder, divisible} !== {1'b1, 1'b0, 8'd7, 3'd5, 1'b0}) bad++;
      tick();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: %0d unstable cycles (q=%0d r=%0d), required 0 with q=7 r=5", bad, quotient, remainder);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'd7, 3'd5}) begin
      miscompares++;
      $display("FAIL backpressure_release: vld=%b rdy=%b q=%0d r=%0d, required vld=0 rdy=1 q=7 r=5",
               out_valid, in_ready, quotient, remainder);
    end
  endtask

  task automatic test_input_ignored();
    bit ok; int lat; int st;
    out_ready = 1'b1;
    accept_one(8'd250, ok, st);
    dividend = 8'd12;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    wait_valid(lat, ok);
    vectors++;
    if ({ok, quotient, remainder, divisible} !== {1'b1, 8'd41, 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL input_ignored: vld=%b q=%0d r=%0d d=%b, required vld=1 q=41 r=4 d=0",
               ok, quotient, remainder, divisible);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; int st; int seen = 0;
    accept_one(8'd200, ok, st);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, divisible} !== {1'b1, 1'b0, 8'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b vld=%b q=%0d r=%0d d=%b, required rdy=1 vld=0 q=0 r=0 d=0",
               in_ready, out_valid, quotient, remainder, divisible);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_abort: out_valid seen %0d cycles after abort, required 0", seen);
    end
    accept_one(8'd12, ok, st);
    wait_valid(lat, ok);
    vectors++;
    if ({ok, quotient, remainder, divisible} !== {1'b1, 8'd2, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_next: vld=%b q=%0d r=%0d d=%b, required vld=1 q=2 r=0 d=1",
               ok, quotient, remainder, divisible);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    bit ok; int lat; int st; int x; int n;
    logic [W-1:0] eq; logic [2:0] er; logic ed; bit done;
    for (int k = 0; k < 256 + 40; k++) begin
      x  = (k < 256) ? k : int'($urandom_range(0, 255));
      eq = W'(x / 6);
      er = 3'(x % 6);
      ed = (x % 6) == 0;
      out_ready = 1'($urandom_range(0, 1));
      accept_one(W'(x), ok, st);
      lat = 0;
      while (!out_valid && lat < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      vectors++;
      if (!out_valid || lat != W) begin
        miscompares++;
        $display("FAIL sweep_latency x=%0d: %0d edges (valid=%b), required %0d", x, lat, out_valid, W);
      end
      done = 1'b0;
      n = 0;
      while (!done && n < 50) begin
        vectors++;
        if ({out_valid, quotient, remainder, divisible} !== {1'b1, eq, er, ed} || remainder > 3'd5) begin
          miscompares++;
          $display("FAIL sweep_result x=%0d: vld=%b q=%0d r=%0d d=%b, required vld=1 q=%0d r=%0d d=%b",
                   x, out_valid, quotient, remainder, divisible, eq, er, ed);
        end
        out_ready = (n >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
        done = out_ready;
        tick();
        n++;
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_handshake x=%0d: out_valid=%b after handshake, required 0", x, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_input_ignored();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divide_6_seq.md
Name: divide_6_seq

Overview:
Sequential bit-serial divider by the constant 6. It accepts a WIDTH-bit unsigned dividend over a valid/ready handshake and processes it MSB-first, one bit per clock, through a mod-6 remainder state machine. It returns the quotient, the remainder and a divisible flag over a second valid/ready handshake. It is the constructive counterpart of the combinational divisibility checkers: those only report whether the remainder is zero, while this block produces the full quotient and remainder.

Parameters:
WIDTH, 8, dividend and quotient width in bits; legal range 3..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend is presented
in_ready  output  1  block can accept a dividend
dividend  input  WIDTH  unsigned dividend, sampled only on acceptance
out_valid  output  1  result is presented
out_ready  input  1  downstream accepts the result
quotient  output  WIDTH  floor(dividend/6)
remainder  output  3  dividend mod 6, range 0..5
divisible  output  1  1 when remainder == 0

Behaviour:
- Reset is asynchronous, active-low, and applies while rst_n=0:
  - state=IDLE
  - in_ready=1, out_valid=0
  - quotient=0, remainder=0, divisible=0
  - shift register and bit counter cleared
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - Acceptance is in_valid & in_ready at a clock edge. On acceptance: latch dividend into the shift register, set the working remainder r=0, set the counter to WIDTH-1, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle: t = 2*r + msb(shift register), computed 4 bits wide (max 11).
  - If t >= 6: quotient bit = 1 and r = t-6. Otherwise: quotient bit = 0 and r = t.
  - The quotient bit shifts into the LSB of the quotient register; the shift register shifts left by one.
  - When counter == 0 after this step, go to DONE. Otherwise decrement the counter.
- DONE:
  - out_valid=1.
  - quotient, remainder and divisible are stable until the handshake completes.
  - On out_valid & out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one division per WIDTH+2 cycles when out_ready is held at 1.
- in_ready is 0 in SHIFT and DONE. A new dividend is never accepted in the same cycle as result delivery.
- Changes on dividend or in_valid after acceptance are ignored.
- Outputs are registered, and remain holding the last result after returning to IDLE until the next acceptance.
- divisible is derived from the final remainder only; it is never asserted mid-computation in a visible way because out_valid=0.
- Back-pressure: out_ready may stay low indefinitely and the result holds. out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation (SHIFT or DONE): immediate return to reset values. The partial result is discarded and out_valid is not asserted.
- Invariant: r is always in 0..5. The internal state must never hold 6 or 7.
- Arithmetic is unsigned only. A dividend of 0 yields quotient 0, remainder 0, divisible 1.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - DIVISOR=6
  - REM_W=3
- One natural combinational sub-module: mod6_step.
  - Inputs: r_in[2:0], bit_in.
  - Outputs: r_out[2:0], q_bit.
  - It implements one restoring-division step and is reusable for the existing divisibility checks.
- Top level holds the FSM, counter, shift and quotient registers, and handshakes.

Test Plan:
1. Reset, then dividend=0 with in_valid pulsed (WIDTH=8) -> out_valid after 8 cycles; quotient=0, remainder=0, divisible=1.
2. dividend=6, then dividend=255 back-to-back with out_ready=1 -> first result quotient=1, remainder=0, divisible=1; second result quotient=42, remainder=3, divisible=0. in_ready must be 0 from acceptance until each result is taken.
3. dividend=47 with out_ready=0 for 20 cycles, then 1 -> result quotient=7, remainder=5, divisible=0 held stable for all 20 cycles; in_ready stays 0; return to IDLE one cycle after the handshake.
4. dividend=250, change dividend to 12 on the cycle after acceptance -> quotient=41, remainder=4 (the change is ignored).
5. Assert rst_n=0 during cycle 4 of SHIFT, release it, then send dividend=12 -> no out_valid for the aborted operation; next result quotient=2, remainder=0, divisible=1.
6. Exhaustive sweep of 0..255 with random out_ready back-pressure -> every result matches floor(x/6), x%6 and (x%6==0); the remainder is never above 5.
